// File: rtl/seq_detect_pkg.sv
// Shared definitions for the serial pattern detector: FSM encoding,
// parameter defaults and the configuration length clamp.
package seq_detect_pkg;

    localparam int MAX_LEN_DEF = 8;
    localparam int CNT_W_DEF   = 8;

    localparam logic [0:0] ST_UNCFG = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    // Lengths above the window size are folded down to the full window.
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned max_len);
        if (len > max_len) begin
            return max_len;
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/seq_match_window.sv
// History shift register, fill counter and masked pattern compare.
// match_o is combinational and only asserts on an accepted bit.
module seq_match_window
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int LEN_W   = $clog2(MAX_LEN_DEF + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               restart_i,
    input  logic               shift_i,
    input  logic               bit_i,
    input  logic [MAX_LEN-1:0] pattern_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic               overlap_i,
    output logic               match_o
);

    logic [MAX_LEN-1:0] hist_q;
    logic [MAX_LEN-1:0] hist_d;
    logic [LEN_W-1:0]   fill_q;
    logic [LEN_W-1:0]   fill_d;
    logic [MAX_LEN-1:0] hist_new_s;
    logic [MAX_LEN-1:0] mask_s;
    logic [LEN_W-1:0]   fill_inc_s;

    // Candidate window including the incoming bit, and the compare against it.
    always_comb begin
        hist_new_s = {hist_q[MAX_LEN-2:0], bit_i};
        if (fill_q >= LEN_W'(MAX_LEN)) begin
            fill_inc_s = fill_q;
        end else begin
            fill_inc_s = fill_q + LEN_W'(1);
        end
        mask_s = {MAX_LEN{1'b0}};
        for (int i = 0; i < MAX_LEN; i++) begin
            mask_s[i] = (LEN_W'(i) < len_i);
        end
        match_o = shift_i && (fill_inc_s >= len_i) &&
                  (((hist_new_s ^ pattern_i) & mask_s) == {MAX_LEN{1'b0}});
    end

    // Next history and fill; a non-overlapping match starts a fresh fill.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (restart_i) begin
            hist_d = {MAX_LEN{1'b0}};
            fill_d = {LEN_W{1'b0}};
        end else if (shift_i) begin
            hist_d = hist_new_s;
            if (match_o && !overlap_i) begin
                fill_d = {LEN_W{1'b0}};
            end else begin
                fill_d = fill_inc_s;
            end
        end else begin
            hist_d = hist_q;
            fill_d = fill_q;
        end
    end

    // Window state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= {MAX_LEN{1'b0}};
            fill_q <= {LEN_W{1'b0}};
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_pattern_detect.sv
// Configurable serial pattern detector: configuration FSM, registered
// match pulse and a saturating match counter around seq_match_window.
module seq_pattern_detect
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             inp_bit,
    input  logic                             inp_valid,
    input  logic                             cfg_load,
    input  logic [MAX_LEN-1:0]               cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0]     cfg_len,
    input  logic                             cfg_overlap,
    input  logic                             cnt_clr,
    output logic                             seq_seen,
    output logic [CNT_W-1:0]                 match_count,
    output logic                             cnt_sat,
    output logic                             armed
);

    localparam int               LEN_W   = $clog2(MAX_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [0:0]         state_q;
    logic [0:0]         state_d;
    logic [MAX_LEN-1:0] pat_q;
    logic [MAX_LEN-1:0] pat_d;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   len_d;
    logic               ovl_q;
    logic               ovl_d;
    logic               seen_q;
    logic               armed_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic               sat_q;
    logic               sat_d;
    logic               accept_s;
    logic               match_s;

    // Configuration FSM; a load always restarts the window.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        if (cfg_load) begin
            if (cfg_len < LEN_W'(2)) begin
                state_d = ST_UNCFG;
            end else begin
                state_d = ST_RUN;
                pat_d   = cfg_pattern;
                len_d   = LEN_W'(clamp_len(32'(cfg_len), int'(MAX_LEN)));
                ovl_d   = cfg_overlap;
            end
        end else begin
            state_d = state_q;
        end
    end

    // A bit is only accepted while running and never alongside a load.
    always_comb begin
        accept_s = 1'b0;
        case (state_q)
            ST_RUN:  accept_s = inp_valid && !cfg_load;
            ST_UNCFG: accept_s = 1'b0;
            default: accept_s = 1'b0;
        endcase
    end

    seq_match_window #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_window (
        .clk       (clk),
        .reset     (reset),
        .restart_i (cfg_load),
        .shift_i   (accept_s),
        .bit_i     (inp_bit),
        .pattern_i (pat_q),
        .len_i     (len_q),
        .overlap_i (ovl_q),
        .match_o   (match_s)
    );

    // Saturating counter; a clear overrides a coincident match.
    always_comb begin
        count_d = count_q;
        sat_d   = sat_q;
        if (cnt_clr) begin
            count_d = {CNT_W{1'b0}};
            sat_d   = 1'b0;
        end else if (match_s) begin
            if (count_q == CNT_MAX) begin
                count_d = count_q;
                sat_d   = 1'b1;
            end else begin
                count_d = count_q + CNT_ONE;
                sat_d   = sat_q || (count_q == (CNT_MAX - CNT_ONE));
            end
        end else begin
            count_d = count_q;
        end
    end

    // Control, configuration and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_UNCFG;
            pat_q   <= {MAX_LEN{1'b0}};
            len_q   <= {LEN_W{1'b0}};
            ovl_q   <= 1'b0;
            seen_q  <= 1'b0;
            armed_q <= 1'b0;
            count_q <= {CNT_W{1'b0}};
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            seen_q  <= match_s;
            armed_q <= (state_d == ST_RUN);
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign seq_seen    = seen_q;
    assign match_count = count_q;
    assign cnt_sat     = sat_q;
    assign armed       = armed_q;

endmodule

// File: tb/tb_seq_pattern_detect.sv
// Scoreboard bench for seq_pattern_detect: directed scenarios plus biased
// random traffic, checked against a queue-of-bits reference model.
module tb_seq_pattern_detect;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               inp_bit = 1'b0;
    logic               inp_valid = 1'b0;
    logic               cfg_load = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic               cnt_clr = 1'b0;
    logic               seq_seen;
    logic [CNT_W-1:0]   match_count;
    logic               cnt_sat;
    logic               armed;

    seq_pattern_detect #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .inp_bit     (inp_bit),
        .inp_valid   (inp_valid),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cnt_clr     (cnt_clr),
        .seq_seen    (seq_seen),
        .match_count (match_count),
        .cnt_sat     (cnt_sat),
        .armed       (armed)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit seen;
        int count;
        bit sat;
        bit armed;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: configuration plus the bits accepted since the last restart.
    bit             m_run = 1'b0;
    int             m_len = 0;
    logic [7:0]     m_pat = '0;
    bit             m_ovl = 1'b0;
    bit             m_bits[$];
    int             m_count = 0;
    bit             m_sat = 1'b0;
    int             pat_idx = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit ld, input logic [7:0] p,
                              input int l, input bit o, input bit v,
                              input bit b, input bit c);
        exp_t e;
        bit   m;
        int   n;
        m = 1'b0;
        if (r) begin
            m_run = 1'b0; m_len = 0; m_pat = '0; m_ovl = 1'b0;
            m_bits.delete(); m_count = 0; m_sat = 1'b0;
        end else begin
            if (ld) begin
                m_bits.delete();
                if (l < 2) begin
                    m_run = 1'b0;
                end else begin
                    m_run = 1'b1;
                    m_len = (l > MAX_LEN) ? MAX_LEN : l;
                    m_pat = p;
                    m_ovl = o;
                end
            end else if (v && m_run) begin
                m_bits.push_back(b);
                if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
                n = m_bits.size();
                if (n >= m_len) begin
                    m = 1'b1;
                    for (int k = 0; k < m_len; k++)
                        if (m_bits[n - m_len + k] != m_pat[m_len - 1 - k]) m = 1'b0;
                end
                if (m && !m_ovl) m_bits.delete();
            end
            if (c) begin
                m_count = 0; m_sat = 1'b0;
            end else if (m) begin
                if (m_count < CNT_MAX) m_count++;
                if (m_count == CNT_MAX) m_sat = 1'b1;
            end
        end
        e.seen  = m;
        e.count = m_count;
        e.sat   = m_sat;
        e.armed = m_run;
        exp_q.push_back(e);
    endtask

    task automatic step(input bit r, input bit ld, input logic [7:0] p,
                        input int l, input bit o, input bit v,
                        input bit b, input bit c);
        @(negedge clk);
        reset       = r;
        cfg_load    = ld;
        cfg_pattern = p;
        cfg_len     = LEN_W'(l);
        cfg_overlap = o;
        inp_valid   = v;
        inp_bit     = b;
        cnt_clr     = c;
        model_step(r, ld, p, l, o, v, b, c);
    endtask

    task automatic send(input bit b);            step(0, 0, 8'h00, 0, 0, 1, b, 0); endtask
    task automatic gap();                        step(0, 0, 8'h00, 0, 0, 0, 0, 0); endtask
    task automatic clr();                        step(0, 0, 8'h00, 0, 0, 0, 0, 1); endtask
    task automatic rst();                        step(1, 0, 8'h00, 0, 0, 0, 0, 0); endtask
    task automatic load(input logic [7:0] p, input int l, input bit o);
        step(0, 1, p, l, o, 0, 0, 0);
    endtask
    task automatic settle();
        @(posedge clk);
        #3;
    endtask

    // Monitor: every cycle the DUT presents a result, compare it to the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("seq_seen",    int'(seq_seen),    int'(e.seen));
                chk("match_count", int'(match_count), e.count);
                chk("cnt_sat",     int'(cnt_sat),     int'(e.sat));
                chk("armed",       int'(armed),       int'(e.armed));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit r, ld, o, v, b, c;
        logic [7:0] p;
        int l;

        rst(); rst();
        settle();
        chk("reset_armed", int'(armed), 0);
        chk("reset_count", int'(match_count), 0);
        chk("reset_seen",  int'(seq_seen), 0);

        // Non-overlapping 1001 over 1,0,0,1,0,0,1.
        load(8'b00001001, 4, 0); clr();
        send(1); send(0); send(0); send(1);
        settle(); chk("r038_pulse", int'(seq_seen), 1);
        send(0); send(0); send(1);
        settle(); chk("r038_count", int'(match_count), 1);

        // Same stream, overlapping.
        load(8'b00001001, 4, 1); clr();
        send(1); send(0); send(0); send(1); send(0); send(0); send(1);
        settle(); chk("r039_pulse", int'(seq_seen), 1);
        chk("r039_count", int'(match_count), 2);

        // len=2 pattern 11 with a valid gap.
        load(8'b00000011, 2, 1); clr();
        send(1); send(1); gap();
        settle(); chk("r040_gap", int'(seq_seen), 0);
        send(1); send(1);
        settle(); chk("r040_count", int'(match_count), 3);

        // Counter saturation and clear coincident with a match.
        load(8'b00000011, 2, 1); clr();
        send(1); send(1); send(1); send(1); send(1);
        settle();
        chk("r041_sat_count", int'(match_count), 3);
        chk("r041_sat_flag",  int'(cnt_sat), 1);
        step(0, 0, 8'h00, 0, 0, 1, 1, 1);
        settle();
        chk("r041_clr_seen",  int'(seq_seen), 1);
        chk("r041_clr_count", int'(match_count), 0);
        chk("r041_clr_sat",   int'(cnt_sat), 0);

        // Reset mid-pattern, then a too-short load.
        load(8'b00001001, 4, 0);
        send(1); send(0); send(0); rst(); send(1);
        settle();
        chk("r042_seen",  int'(seq_seen), 0);
        chk("r042_armed", int'(armed), 0);
        load(8'b00000001, 1, 0);
        settle(); chk("r042_len1_armed", int'(armed), 0);

        // Load coincident with the completing bit.
        load(8'b00001001, 4, 0);
        send(1); send(0); send(0);
        step(0, 1, 8'b00001001, 4, 0, 1, 1, 0);
        settle();
        chk("r043_seen",  int'(seq_seen), 0);
        chk("r043_armed", int'(armed), 1);
        send(1); send(0); send(0);
        settle(); chk("r043_restart", int'(seq_seen), 0);
        send(1);
        settle(); chk("r043_fresh_match", int'(seq_seen), 1);

        // Oversized length clamps to the full window.
        load(8'b10110010, 15, 1);
        for (int i = 0; i < 8; i++) send(1'b1 & (8'b10110010 >> (7 - i)));
        settle(); chk("clamp_match", int'(seq_seen), 1);

        // Biased random traffic.
        for (int n = 0; n < 1500; n++) begin
            r  = ($urandom_range(0, 299) == 0);
            ld = ($urandom_range(0, 39) == 0) || (!m_run && $urandom_range(0, 7) == 0);
            p  = 8'($urandom);
            l  = ($urandom_range(0, 9) < 6) ? int'($urandom_range(2, 4)) : int'($urandom_range(0, 15));
            o  = 1'($urandom);
            v  = ($urandom_range(0, 3) != 0);
            c  = ($urandom_range(0, 49) == 0);
            if (m_run && m_len >= 2 && $urandom_range(0, 3) != 0) begin
                b = m_pat[m_len - 1 - (pat_idx % m_len)];
            end else begin
                b = 1'($urandom);
            end
            if (ld || r) pat_idx = 0;
            else if (v) pat_idx = (m_len > 0) ? (pat_idx + 1) % m_len : 0;
            step(r, ld, p, l, o, v, b, c);
        end

        gap(); gap();
        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_pattern_detect.md
SEQ_PATTERN_DETECT -- requirements
Module: seq_pattern_detect

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: port clk is the clock and port reset is the reset.
REQ-002 Parameter MAX_LEN SHALL default to 8 and set the longest detectable pattern; legal range is 2..16.
REQ-003 Parameter CNT_W SHALL default to 8 and set the match counter width.
REQ-004 Parameter LEN_W SHALL be derived as clog2(MAX_LEN+1) and SHALL not be overridden.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 inp_bit  in  1  serial data bit.
REQ-008 inp_valid  in  1  inp_bit qualifier; the bit is accepted on an edge where inp_valid=1.
REQ-009 cfg_load  in  1  one-cycle strobe that captures cfg_pattern, cfg_len and cfg_overlap.
REQ-010 cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first serial bit and bit [0] is the last.
REQ-011 cfg_len  in  LEN_W  active pattern length.
REQ-012 cfg_overlap  in  1  1=overlapping detection, 0=non-overlapping.
REQ-013 cnt_clr  in  1  synchronous clear of match_count and cnt_sat.
REQ-014 seq_seen  out  1  registered one-cycle match pulse.
REQ-015 match_count  out  CNT_W  saturating count of matches.
REQ-016 cnt_sat  out  1  sticky flag, set when match_count reaches all-ones.
REQ-017 armed  out  1  high when a valid configuration is loaded and the block is in RUN.

Function
REQ-018 The control FSM SHALL have two states: UNCFG (no valid configuration) and RUN.
REQ-019 On cfg_load with 2<=cfg_len<=MAX_LEN, the FSM SHALL go to RUN, latch the configuration, clear the history and clear the fill count.
REQ-020 On cfg_load with cfg_len<2, the FSM SHALL go to UNCFG.
REQ-021 On cfg_load with cfg_len>MAX_LEN, the latched length SHALL clamp to MAX_LEN and the FSM SHALL go to RUN.
REQ-022 In RUN, each accepted bit SHALL shift into the history register and increment the fill count, saturating at MAX_LEN.
REQ-023 A match SHALL occur on an accept edge when fill (including the new bit) >= len and the low len history bits equal the low len cfg_pattern bits.
REQ-024 seq_seen SHALL be high in exactly the cycle following the match edge; latency is 1 cycle from the accepting edge.
REQ-025 Non-overlap mode: a match SHALL clear the fill count, so the next match needs len fresh accepted bits.
REQ-026 Overlap mode: a match SHALL leave the fill count unchanged, so back-to-back matches are possible.
REQ-027 Cycles with inp_valid=0 SHALL not change the history or the fill count, and SHALL force seq_seen=0 in the following cycle.
REQ-028 If cfg_load and inp_valid are high on the same edge, cfg_load SHALL win; the bit is discarded and no match is produced.
REQ-029 In UNCFG, accepted bits SHALL be ignored and seq_seen SHALL stay 0.
REQ-030 Each match SHALL increment match_count; at all-ones the count SHALL hold and cnt_sat SHALL set and remain set until cleared.
REQ-031 If cnt_clr and a match occur on the same edge, cnt_clr SHALL win: match_count becomes 0 and cnt_sat becomes 0, while seq_seen still pulses.
REQ-032 armed SHALL equal (state==RUN).

Reset
REQ-033 On reset, the state SHALL be UNCFG, and history, fill count, latched configuration, seq_seen, match_count, cnt_sat and armed SHALL all be 0.
REQ-034 Reset SHALL take priority over cfg_load, cnt_clr and inp_valid, including when it is asserted mid-pattern.

Structure
REQ-035 A shared package seq_detect_pkg SHALL hold the FSM state encoding (UNCFG=0, RUN=1) and the default values of MAX_LEN and CNT_W.
REQ-036 The history shift register, fill counter and masked compare SHALL live in one sub-module, seq_match_window, which outputs a combinational match signal.
REQ-037 The top level SHALL hold the FSM, the configuration registers, the seq_seen register and the counter.

Verification
REQ-038 Load pattern=8'b00001001, len=4, overlap=0, then stream 1,0,0,1,0,0,1 -> exactly one seq_seen pulse, one cycle after the 4th bit; match_count=1.
REQ-039 Same stream with overlap=1 -> seq_seen pulses after bits 4 and 7; match_count=2.
REQ-040 len=2, pattern=2'b11, overlap=1, stream 1,1,1,1 with inp_valid=0 inserted between bits 2 and 3 -> pulses after bits 2, 3 and 4, with no pulse during the gap cycle.
REQ-041 CNT_W=2, drive 4 matches -> match_count=3 and cnt_sat=1; then cnt_clr coincident with a 5th match -> seq_seen=1, match_count=0, cnt_sat=0.
REQ-042 Assert reset after 3 of the 4 pattern bits, then send the 4th bit -> no pulse, armed=0; cfg_load with len=1 -> armed stays 0.
REQ-043 cfg_load coincident with the completing bit -> no pulse; the history restarts empty.
